// File: rtl/char_motion_engine.sv
// Per-frame player physics: walk, jump, gravity,
// terminal velocity, and ceiling/floor/wall clamping.
module char_motion_engine #(
  parameter int         X_START   = 320,
  parameter int         Y_START   = 240,
  parameter int         X_MIN     = 0,
  parameter int         X_MAX     = 639,
  parameter int         Y_MIN     = 0,
  parameter int         Y_MAX     = 300,
  parameter int         SIZE      = 4,
  parameter int         X_STEP    = 1,
  parameter int         JUMP_VEL  = 8,
  parameter int         GRAVITY   = 1,
  parameter int         MAX_FALL  = 8,
  parameter logic [7:0] KEY_LEFT  = 8'h04,
  parameter logic [7:0] KEY_RIGHT = 8'h07,
  parameter logic [7:0] KEY_JUMP  = 8'h2C
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  output logic [9:0] CharX,
  output logic [9:0] CharY,
  output logic [9:0] CharS,
  output logic [1:0] state,
  output logic       on_ground
);

  typedef enum logic [1:0] {
    GROUND = 2'd0,
    RISE   = 2'd1,
    FALL   = 2'd2
  } state_t;

  localparam logic signed [11:0] C_XLO =
    12'(X_MIN + SIZE);
  localparam logic signed [11:0] C_XHI =
    12'(X_MAX - SIZE);
  localparam logic signed [11:0] C_YLO =
    12'(Y_MIN + SIZE);
  localparam logic signed [11:0] C_YFLR =
    12'(Y_MAX - SIZE);
  localparam logic signed [11:0] C_YMAX =
    12'(Y_MAX);
  localparam logic signed [11:0] C_SIZE =
    12'(SIZE);
  localparam logic signed [11:0] C_XSTEP =
    12'(X_STEP);
  localparam logic signed [11:0] C_GRAV =
    12'(GRAVITY);
  localparam logic signed [11:0] C_MFALL =
    12'(MAX_FALL);
  localparam logic signed [10:0] C_VJUMP =
    11'(0 - JUMP_VEL);
  localparam logic [9:0] C_X0 = 10'(X_START);
  localparam logic [9:0] C_Y0 = 10'(Y_START);
  localparam state_t C_ST0 =
    (Y_START + SIZE < Y_MAX) ? FALL : GROUND;

  // Saturate a wide signed position into 10 bits.
  function automatic logic [9:0] sat10(
    input logic signed [11:0] v
  );
    if (v < 0)
      return 10'd0;
    else if (v > 12'sd1023)
      return 10'h3FF;
    else
      return v[9:0];
  endfunction

  state_t            st, st_n;
  logic signed [10:0] vy, vy_n;
  logic              armed, armed_n;
  logic [9:0]        x_n, y_n;
  logic              k_left, k_right, k_jump;
  logic signed [11:0] xs, sx;
  logic signed [11:0] ys, vw, ny, nv;

  // Key is down when either keyboard slot holds it.
  always_comb begin
    k_left  = (keycode0 == KEY_LEFT)  ||
              (keycode1 == KEY_LEFT);
    k_right = (keycode0 == KEY_RIGHT) ||
              (keycode1 == KEY_RIGHT);
    k_jump  = (keycode0 == KEY_JUMP)  ||
              (keycode1 == KEY_JUMP);
  end

  // Horizontal step with wall clamping.
  always_comb begin
    xs = signed'({2'b00, CharX});
    sx = xs;
    if (k_left && !k_right) begin
      sx = xs - C_XSTEP;
      if (sx < C_XLO)
        sx = C_XLO;
    end else if (k_right && !k_left) begin
      sx = xs + C_XSTEP;
      if (sx > C_XHI)
        sx = C_XHI;
    end
    x_n = sat10(sx);
  end

  // Vertical state machine: next Y, vy and state.
  always_comb begin
    st_n    = st;
    y_n     = CharY;
    vy_n    = vy;
    armed_n = armed | ~k_jump;
    ys      = signed'({2'b00, CharY});
    vw      = {vy[10], vy};
    ny      = ys;
    nv      = vw;
    unique case (st)
      GROUND: begin
        if (k_jump && armed) begin
          vy_n    = C_VJUMP;
          st_n    = RISE;
          armed_n = 1'b0;
        end
      end
      RISE: begin
        ny = ys + vw;
        nv = vw + C_GRAV;
        if (ny < C_YLO) begin
          y_n  = sat10(C_YLO);
          vy_n = '0;
          st_n = FALL;
        end else begin
          y_n  = sat10(ny);
          vy_n = nv[10:0];
          if (!nv[11])
            st_n = FALL;
        end
      end
      FALL: begin
        nv = vw + C_GRAV;
        if (nv > C_MFALL)
          nv = C_MFALL;
        ny = ys + nv;
        if (ny + C_SIZE >= C_YMAX) begin
          y_n  = sat10(C_YFLR);
          vy_n = '0;
          st_n = GROUND;
        end else begin
          y_n  = sat10(ny);
          vy_n = nv[10:0];
        end
      end
      default: begin
        st_n = FALL;
      end
    endcase
  end

  // Registers update only on a frame tick; reset wins.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      CharX <= C_X0;
      CharY <= C_Y0;
      vy    <= '0;
      armed <= 1'b1;
      st    <= C_ST0;
    end else if (frame_tick) begin
      CharX <= x_n;
      CharY <= y_n;
      vy    <= vy_n;
      armed <= armed_n;
      st    <= st_n;
    end
  end

  assign CharS     = 10'(SIZE);
  assign state     = st;
  assign on_ground = (st == GROUND);

endmodule

// File: tb/tb_char_motion_engine.sv
// Scoreboard bench for char_motion_engine:
// default instance plus a high-jump instance.
module tb_char_motion_engine;

  localparam logic [7:0] SP = 8'h2C;
  localparam logic [7:0] KA = 8'h04;
  localparam logic [7:0] KD = 8'h07;
  localparam logic [1:0] G  = 2'd0;
  localparam logic [1:0] R  = 2'd1;
  localparam logic [1:0] F  = 2'd2;

  logic       CLK = 1'b0;
  logic       rst1, tick1, rst2, tick2;
  logic [7:0] a1, b1, a2, b2;
  logic [9:0] x1, y1, s1, x2, y2, s2;
  logic [1:0] st1, st2;
  logic       og1, og2;

  typedef struct {
    bit         dut;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] st;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  always #5 CLK = ~CLK;

  char_motion_engine dut1 (
    .CLK(CLK), .Reset(rst1),
    .frame_tick(tick1),
    .keycode0(a1), .keycode1(b1),
    .CharX(x1), .CharY(y1), .CharS(s1),
    .state(st1), .on_ground(og1)
  );

  char_motion_engine #(
    .Y_START(20), .JUMP_VEL(30)
  ) dut2 (
    .CLK(CLK), .Reset(rst2),
    .frame_tick(tick2),
    .keycode0(a2), .keycode1(b2),
    .CharX(x2), .CharY(y2), .CharS(s2),
    .state(st2), .on_ground(og2)
  );

  // Monitor: pop one expectation per cycle and compare.
  always @(negedge CLK) begin : mon
    exp_t       e;
    logic [9:0] ax, ay, as;
    logic [1:0] ast;
    logic       aog;
    if (q.size() > 0) begin
      e   = q.pop_front();
      ax  = e.dut ? x2  : x1;
      ay  = e.dut ? y2  : y1;
      as  = e.dut ? s2  : s1;
      ast = e.dut ? st2 : st1;
      aog = e.dut ? og2 : og1;
      checks++;
      if (ax == e.x && ay == e.y &&
          ast == e.st && as == 10'd4 &&
          aog == (e.st == G))
        passed++;
      else
        $display(
          "FAIL %s: got x=%0d y=%0d st=%0d og=%0b s=%0d want x=%0d y=%0d st=%0d s=4",
          e.name, ax, ay, ast, aog, as,
          e.x, e.y, e.st);
    end
  end

  task automatic expect_out(
    input bit d, input int ex, input int ey,
    input logic [1:0] es, input string nm
  );
    exp_t e;
    e.dut  = d;
    e.x    = 10'(ex);
    e.y    = 10'(ey);
    e.st   = es;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic step(
    input bit d, input bit tk,
    input logic [7:0] ka, input logic [7:0] kb,
    input int ex, input int ey,
    input logic [1:0] es, input string nm
  );
    @(negedge CLK);
    if (d) begin
      tick2 = tk; a2 = ka; b2 = kb;
    end else begin
      tick1 = tk; a1 = ka; b1 = kb;
    end
    @(posedge CLK);
    #1;
    tick1 = 1'b0;
    tick2 = 1'b0;
    expect_out(d, ex, ey, es, nm);
  endtask

  task automatic do_reset(
    input bit d, input bit tk,
    input logic [7:0] ka, input logic [7:0] kb,
    input int ey, input string nm
  );
    @(negedge CLK);
    if (d) begin
      rst2 = 1'b1; tick2 = tk; a2 = ka; b2 = kb;
    end else begin
      rst1 = 1'b1; tick1 = tk; a1 = ka; b1 = kb;
    end
    @(posedge CLK);
    #1;
    rst1  = 1'b0;
    rst2  = d ? 1'b0 : rst2;
    tick1 = 1'b0;
    tick2 = 1'b0;
    expect_out(d, 320, ey, F, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int t1[11] = '{241, 243, 246, 250, 255, 261,
                   268, 276, 284, 292, 296};
    int t2[8]  = '{288, 281, 275, 270,
                   266, 263, 261, 260};
    int t3[8]  = '{261, 263, 266, 270,
                   275, 281, 288, 296};
    int t4[4]  = '{5, 4, 4, 4};
    int t5[8]  = '{21, 23, 26, 30,
                   35, 41, 48, 56};
    int t6[12] = '{266, 237, 209, 182, 156, 131,
                   107, 84, 62, 41, 21, 4};
    rst1 = 1'b1; rst2 = 1'b1;
    tick1 = 1'b0; tick2 = 1'b0;
    a1 = '0; b1 = '0; a2 = '0; b2 = '0;
    repeat (2) @(posedge CLK);

    do_reset(0, 0, 8'h00, 8'h00, 240, "reset");
    for (int i = 0; i < 11; i++)
      step(0, 1, 8'h00, 8'h00, 320, t1[i],
           (i == 10) ? G : F, "fall_in");

    step(0, 1, 8'h00, SP, 320, 296, R,
         "jump_start");
    for (int i = 0; i < 8; i++)
      step(0, 1, SP, 8'h00, 320, t2[i],
           (i == 7) ? F : R, "rise");
    for (int i = 0; i < 8; i++)
      step(0, 1, 8'h00, SP, 320, t3[i],
           (i == 7) ? G : F, "fall_land");
    for (int i = 0; i < 2; i++)
      step(0, 1, SP, 8'h00, 320, 296, G,
           "hold_no_rejump");
    step(0, 1, 8'h00, 8'h00, 320, 296, G,
         "release");
    step(0, 1, SP, 8'h00, 320, 296, R,
         "rejump");
    step(0, 1, SP, 8'h00, 320, 288, R,
         "rejump_rise");

    do_reset(0, 1, KD, 8'h00, 240,
             "reset_mid_rise");
    for (int i = 0; i < 11; i++)
      step(0, 1, 8'h00, 8'h00, 320, t1[i],
           (i == 10) ? G : F, "post_reset");
    for (int i = 0; i < 5; i++)
      step(0, 0, KA, SP, 320, 296, G,
           "stable_no_tick");

    for (int i = 1; i <= 314; i++)
      step(0, 1, KA, 8'h00, 320 - i, 296, G,
           "walk_left");
    for (int i = 0; i < 4; i++)
      step(0, 1, 8'h00, KA, t4[i], 296, G,
           "left_wall");
    for (int i = 1; i <= 630; i++)
      step(0, 1, KD, 8'h00, 4 + i, 296, G,
           "walk_right");
    for (int i = 0; i < 2; i++)
      step(0, 1, 8'h00, KD, 635, 296, G,
           "right_wall");
    for (int i = 0; i < 2; i++)
      step(0, 1, KA, KD, 635, 296, G,
           "both_keys");

    do_reset(1, 0, 8'h00, 8'h00, 20,
             "hj_reset");
    for (int i = 0; i < 8; i++)
      step(1, 1, 8'h00, 8'h00, 320, t5[i], F,
           "hj_fall_acc");
    for (int k = 1; k <= 29; k++)
      step(1, 1, 8'h00, 8'h00, 320, 56 + 8 * k,
           F, "hj_fall_term");
    step(1, 1, 8'h00, 8'h00, 320, 296, G,
         "hj_land");
    step(1, 1, SP, 8'h00, 320, 296, R,
         "hj_jump");
    for (int i = 0; i < 12; i++)
      step(1, 1, SP, 8'h00, 320, t6[i],
           (i == 11) ? F : R, "hj_ceiling");
    step(1, 1, SP, 8'h00, 320, 5, F,
         "hj_after_bump");

    repeat (3) @(negedge CLK);
    checks++;
    if (q.size() == 0)
      passed++;
    else
      $display("FAIL drain: got %0d left want 0",
               q.size());
    $display("%0d/%0d checks passed",
             passed, checks);
    $finish;
  end

endmodule
